bcd_timer_display: RTL and testbench

- Four-digit decimal up-counter / countdown timer driving four 7-segment digits.
- Preset arrives as 16-bit packed BCD (4 nibbles) and is converted to binary 0..9999.
- A binary count register advances once per prescaled tick; its value is converted back to BCD and decoded to segments.
- Sits between the keypad/preset logic and the board's four seven-segment displays.

---
 rtl/bcd_timer_pkg.sv | 26 ++
 rtl/bcd_timer_display_seg7_digit.sv | 32 +++
 rtl/bcd_timer_display.sv | 76 +++++++
 tb/tb_bcd_timer_display.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/bcd_timer_pkg.sv
// rtl/bcd_timer_pkg.sv - shared widths, digit type and seven-segment patterns
package bcd_timer_pkg;

  localparam int COUNT_W   = 14;
  localparam int MAX_COUNT = 9999;

  typedef logic [3:0] digit_t;

  // Active-high patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  function automatic digit_t clamp_digit(input digit_t d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

endpackage

// File: rtl/bcd_timer_display_seg7_digit.sv
// rtl/bcd_timer_display_seg7_digit.sv - one BCD digit to seven-segment decoder
import bcd_timer_pkg::*;

module seg7_digit #(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  digit_t     digit_i,
  output logic [6:0] seg_o
);

  logic [6:0] pattern;

  always_comb begin
    pattern = SEG_BLANK;
    case (digit_i)
      4'd0: pattern = SEG_0;
      4'd1: pattern = SEG_1;
      4'd2: pattern = SEG_2;
      4'd3: pattern = SEG_3;
      4'd4: pattern = SEG_4;
      4'd5: pattern = SEG_5;
      4'd6: pattern = SEG_6;
      4'd7: pattern = SEG_7;
      4'd8: pattern = SEG_8;
      4'd9: pattern = SEG_9;
      default: pattern = SEG_BLANK;
    endcase
  end

  assign seg_o = SEG_ACTIVE_LOW ? ~pattern : pattern;

endmodule

// File: rtl/bcd_timer_display.sv
// rtl/bcd_timer_display.sv - four-digit BCD up-counter / countdown timer with 7-segment outputs
import bcd_timer_pkg::*;

module bcd_timer_display #(
  parameter int TICK_DIV       = 50_000_000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mode,
  input  logic        load,
  input  logic [15:0] preset_bcd,
  output logic        done,
  output logic [6:0]  seg1,
  output logic [6:0]  seg2,
  output logic [6:0]  seg3,
  output logic [6:0]  seg4
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);

  logic               run_mode_q;
  logic [COUNT_W-1:0] limit_q;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [PW-1:0]      presc_q;
  logic [COUNT_W-1:0] preset_bin;
  logic               tick;
  digit_t             dig [4];

  // Out-of-range nibbles clamp to 9 so any preset lands in 0..9999
  always_comb begin
    preset_bin = COUNT_W'(clamp_digit(preset_bcd[15:12])) * COUNT_W'(1000)
               + COUNT_W'(clamp_digit(preset_bcd[11:8]))  * COUNT_W'(100)
               + COUNT_W'(clamp_digit(preset_bcd[7:4]))   * COUNT_W'(10)
               + COUNT_W'(clamp_digit(preset_bcd[3:0]));
  end

  assign tick = (presc_q == PS_LAST);

  always_comb begin
    count_d = count_q;
    if (run_mode_q) begin
      if (count_q != '0) count_d = count_q - COUNT_W'(1);
    end else begin
      if (count_q < limit_q) count_d = count_q + COUNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || load) begin
      run_mode_q <= mode;
      limit_q    <= preset_bin;
      count_q    <= mode ? preset_bin : '0;
      presc_q    <= '0;
    end else begin
      presc_q <= tick ? '0 : presc_q + PW'(1);
      if (tick) count_q <= count_d;
    end
  end

  assign done = run_mode_q ? (count_q == '0) : (count_q == limit_q);

  always_comb begin
    dig[3] = digit_t'(count_q / COUNT_W'(1000));
    dig[2] = digit_t'((count_q / COUNT_W'(100)) % COUNT_W'(10));
    dig[1] = digit_t'((count_q / COUNT_W'(10)) % COUNT_W'(10));
    dig[0] = digit_t'(count_q % COUNT_W'(10));
  end

  seg7_digit #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_dig1 (.digit_i(dig[3]), .seg_o(seg1));
  seg7_digit #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_dig2 (.digit_i(dig[2]), .seg_o(seg2));
  seg7_digit #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_dig3 (.digit_i(dig[1]), .seg_o(seg3));
  seg7_digit #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_dig4 (.digit_i(dig[0]), .seg_o(seg4));

endmodule

// File: tb/tb_bcd_timer_display.sv
// tb/tb_bcd_timer_display.sv - directed and random checks of bcd_timer_display against a reference model
module tb_bcd_timer_display;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mode = 1'b1;
  logic        load = 1'b0;
  logic [15:0] preset = 16'h9999;
  logic        done_a, done_b;
  logic [6:0]  a1, a2, a3, a4, b1, b2, b3, b4;

  int errors = 0;
  int checks = 0;

  // Reference state: plain integers, ticks counted as cycles since last start
  int m_count, m_limit, m_phase;
  logic m_mode;

  logic [6:0] PAT [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                          7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

  always #5 clk = ~clk;

  bcd_timer_display #(.TICK_DIV(4), .SEG_ACTIVE_LOW(1'b0)) dut_a (
    .clk(clk), .rst(rst), .mode(mode), .load(load), .preset_bcd(preset),
    .done(done_a), .seg1(a1), .seg2(a2), .seg3(a3), .seg4(a4)
  );

  bcd_timer_display #(.TICK_DIV(4), .SEG_ACTIVE_LOW(1'b1)) dut_b (
    .clk(clk), .rst(rst), .mode(mode), .load(load), .preset_bcd(preset),
    .done(done_b), .seg1(b1), .seg2(b2), .seg3(b3), .seg4(b4)
  );

  function automatic int bcd_value(input logic [15:0] p);
    int v = 0;
    for (int k = 3; k >= 0; k--) begin
      int n = int'((p >> (4 * k)) & 16'hF);
      if (n > 9) n = 9;
      v = v * 10 + n;
    end
    return v;
  endfunction

  function automatic logic [27:0] exp_segs(input int c);
    return {PAT[(c / 1000) % 10], PAT[(c / 100) % 10], PAT[(c / 10) % 10], PAT[c % 10]};
  endfunction

  task automatic chk(input string tag, input logic [27:0] obs, input logic [27:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic l, input logic m, input logic [15:0] p);
    if (r || l) begin
      m_mode  = m;
      m_limit = bcd_value(p);
      m_count = m ? m_limit : 0;
      m_phase = 0;
    end else if (m_phase == 3) begin
      m_phase = 0;
      if (m_mode && m_count > 0) m_count--;
      else if (!m_mode && m_count < m_limit) m_count++;
    end else begin
      m_phase++;
    end
  endtask

  task automatic check_all();
    logic exp_done;
    exp_done = m_mode ? (m_count == 0) : (m_count == m_limit);
    chk("segs_a", 28'({a1, a2, a3, a4}), exp_segs(m_count));
    chk("segs_b", 28'({b1, b2, b3, b4}), ~exp_segs(m_count));
    chk("done_a", 28'(done_a), 28'(exp_done));
    chk("done_b", 28'(done_b), 28'(exp_done));
  endtask

  task automatic cyc(input logic r, input logic l, input logic m, input logic [15:0] p);
    rst = r; load = l; mode = m; preset = p;
    @(posedge clk);
    model_edge(r, l, m, p);
    #1;
    check_all();
  endtask

  task automatic idle(input int n, input logic m);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, m, preset);
  endtask

  initial begin
    cyc(1'b1, 1'b0, 1'b1, 16'h9999);
    chk("reset_seg1_9", 28'(a1), 28'(7'b1101111));
    chk("reset_seg4_9", 28'(a4), 28'(7'b1101111));
    chk("reset_done", 28'(done_a), 28'(1'b0));
    idle(4, 1'b0);
    chk("timer_9998", 28'({a1, a2, a3, a4}),
        {7'b1101111, 7'b1101111, 7'b1101111, 7'b1111111});
    idle(4, 1'b1);
    chk("timer_9997_u", 28'(a4), 28'(7'b0000111));

    cyc(1'b0, 1'b1, 1'b1, 16'h0002);
    chk("load_0002", 28'(a4), 28'(7'b1011011));
    idle(8, 1'b0);
    chk("timer_zero_done", 28'(done_a), 28'(1'b1));
    idle(40, 1'b1);
    chk("timer_hold_zero", 28'({done_a, a4}), 28'({1'b1, 7'b0111111}));

    cyc(1'b0, 1'b1, 1'b0, 16'h0012);
    chk("up_start_0", 28'({done_a, a4}), 28'({1'b0, 7'b0111111}));
    for (int i = 0; i < 60; i++) cyc(1'b0, 1'b0, i[2], 16'h4321);
    chk("up_hold_12", 28'({done_a, a3, a4}), 28'({1'b1, 7'b0000110, 7'b1011011}));

    cyc(1'b0, 1'b1, 1'b1, 16'hFAFF);
    chk("clamp_9999", 28'({a1, a2, a3, a4}), {4{7'b1101111}});
    cyc(1'b0, 1'b1, 1'b0, 16'h0000);
    chk("zero_done", 28'(done_a), 28'(1'b1));

    cyc(1'b0, 1'b1, 1'b0, 16'h0030);
    idle(6, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 16'h0500);
    chk("midload_0500", 28'({a2, a4}), 28'({7'b1101101, 7'b0111111}));
    idle(3, 1'b0);
    chk("midload_hold", 28'(a4), 28'(7'b0111111));
    idle(1, 1'b0);
    chk("midload_0499", 28'(a4), 28'(7'b1101111));

    cyc(1'b1, 1'b1, 1'b0, 16'h0003);
    chk("rst_and_load", 28'({done_a, a4}), 28'({1'b0, 7'b0111111}));

    cyc(1'b0, 1'b1, 1'b0, 16'h0008);
    idle(36, 1'b1);
    chk("low_8", 28'(b4), 28'(7'b0000000));
    cyc(1'b0, 1'b1, 1'b1, 16'h0001);
    chk("low_1", 28'(b4), 28'(7'b1111001));

    for (int i = 0; i < 3000; i++) begin
      logic r, l, m;
      logic [15:0] p;
      r = ($urandom_range(0, 199) == 0);
      l = ($urandom_range(0, 59) == 0);
      m = 1'($urandom);
      p = ($urandom_range(0, 1) == 0) ? 16'($urandom)
                                       : {8'h00, 4'($urandom_range(0, 2)), 4'($urandom)};
      cyc(r, l, m, p);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
